// File: rtl/dnn_sim_pkg.sv
// Shared helpers for the lane-alignment shifters: power-of-two rotate and config check.
// Also consumed by the forward-shifter bench model.
package dnn_sim_pkg;

  localparam int MAX_W       = 64;
  localparam int UNROT_CTRL  = 3;
  localparam int UNROT_WIDTH = 2 ** UNROT_CTRL;

  // Rotate the low `width` bits of data right by 2**k; bits at or above width come back 0.
  function automatic logic [MAX_W-1:0] rotr_pow2(input logic [MAX_W-1:0] data,
                                                 input int width, input int k);
    logic [MAX_W-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < width) begin
        idx  = (j + (1 << k)) % width;
        r[j] = data[idx[5:0]];
      end
    end
    return r;
  endfunction

  function automatic bit cfg_ok(input int ctrl, input int width);
    return (width == (1 << ctrl)) && (width <= MAX_W);
  endfunction

endpackage

// File: rtl/unshift_stage.sv
// One elastic register stage of the un-shifter: conditionally rotates right by 2**K
// when shift bit K is set, carrying the shift amount and tag along unchanged.
module unshift_stage
  import dnn_sim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CTRL  = 3,
  parameter int TAGW  = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CTRL-1:0]  in_shift,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CTRL-1:0]  out_shift,
  output logic [TAGW-1:0]  out_tag
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CTRL-1:0]  s_q, s_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [WIDTH-1:0] d_rot;

  always_comb begin
    in_ready = !v_q || out_ready;
    d_rot    = WIDTH'(rotr_pow2(MAX_W'(in_data), WIDTH, K));
    v_d      = v_q;
    d_d      = d_q;
    s_d      = s_q;
    tag_d    = tag_q;
    // An empty or draining stage takes whatever is offered, including a bubble.
    if (in_ready) v_d = in_valid;
    if (in_valid && in_ready) begin
      d_d   = in_shift[K] ? d_rot : in_data;
      s_d   = in_shift;
      tag_d = in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      d_q   <= '0;
      s_q   <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      s_q   <= s_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;
  assign out_shift = s_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/unshifter_pipe.sv
// Pipelined rotate-right un-shifter, one stage per shift bit, valid/ready on both sides.
// Define UNROT_OCC_EN to add the `occ` port (count of occupied stages).
module unshifter_pipe
  import dnn_sim_pkg::*;
#(
  parameter int CTRL  = 3,
  parameter int WIDTH = 2 ** CTRL,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CTRL-1:0]  in_shift,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
`ifdef UNROT_OCC_EN
  ,
  output logic [CTRL:0]    occ
`endif
);

  if (!cfg_ok(CTRL, WIDTH)) begin : g_cfg_err
    $error("unshifter_pipe: WIDTH must equal 2**CTRL");
  end

  logic [CTRL:0]            v;
  logic [CTRL:0][WIDTH-1:0] d;
  logic [CTRL:0][CTRL-1:0]  s;
  logic [CTRL:0][TAGW-1:0]  tag;
  logic                     unused_shift;

  assign v[0]   = in_valid;
  assign d[0]   = in_data;
  assign s[0]   = in_shift;
  assign tag[0] = in_tag;

  // Ready is chained through per-stage signals so the combinational path stays acyclic.
  for (genvar k = 0; k < CTRL; k++) begin : g_stage
    logic rdy;
    logic nxt_rdy;
    if (k == CTRL - 1) begin : g_last
      assign nxt_rdy = out_ready;
    end else begin : g_mid
      assign nxt_rdy = g_stage[k+1].rdy;
    end
    unshift_stage #(.WIDTH(WIDTH), .CTRL(CTRL), .TAGW(TAGW), .K(k)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v[k]),
      .in_ready (rdy),
      .in_data  (d[k]),
      .in_shift (s[k]),
      .in_tag   (tag[k]),
      .out_valid(v[k+1]),
      .out_ready(nxt_rdy),
      .out_data (d[k+1]),
      .out_shift(s[k+1]),
      .out_tag  (tag[k+1])
    );
  end

  assign in_ready     = g_stage[0].rdy;
  assign out_valid    = v[CTRL];
  assign out_data     = d[CTRL];
  assign out_tag      = tag[CTRL];
  assign unused_shift = ^s[CTRL];

`ifdef UNROT_OCC_EN
  always_comb begin
    occ = '0;
    for (int k = 1; k <= CTRL; k++) occ = occ + (CTRL+1)'(v[k]);
  end
`endif

endmodule
